fitness_evaluator: RTL and testbench

Sequential fitness stage that sits directly downstream of the evolvable logic-element grid. On `start` it sweeps every input vector, drives each onto the grid inputs and waits a programmable settle time. It then compares the grid outputs against a target truth table and accumulates the number of matching output bits. The result is the candidate's fitness score for the genetic-algorithm controller.

---
 rtl/fitness_evaluator_pkg.sv | 10 +
 rtl/fitness_evaluator_match_popcount.sv | 15 +
 rtl/fitness_evaluator.sv | 91 +++++++++
 tb/tb_fitness_evaluator.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fitness_evaluator_pkg.sv
// fitness_evaluator_pkg: shared grid dimensions, derived widths and fitness FSM states
package fitness_evaluator_pkg;
  localparam int IN    = 2;
  localparam int OUT   = 2;
  localparam int ROW   = 4;
  localparam int COL   = 4;
  localparam int NVEC  = 1 << IN;
  localparam int FIT_W = $clog2(OUT * NVEC + 1);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} fit_state_t;
endpackage

// File: rtl/fitness_evaluator_match_popcount.sv
// match_popcount: number of bit positions where two vectors agree
module match_popcount #(
  parameter int W  = 2,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic [CW-1:0] o_cnt
);
  // sum the XNOR of every bit pair
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < W; i++) o_cnt = o_cnt + CW'(i_a[i] ~^ i_b[i]);
  end
endmodule

// File: rtl/fitness_evaluator.sv
// fitness_evaluator: sweeps all grid input vectors and counts output bits matching a target truth table
module fitness_evaluator
  import fitness_evaluator_pkg::*;
#(
  parameter int IN     = fitness_evaluator_pkg::IN,
  parameter int OUT    = fitness_evaluator_pkg::OUT,
  parameter int SETTLE = 2,
  parameter int FIT_W  = $clog2(OUT * (1 << IN) + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [OUT-1:0][(1<<IN)-1:0]   target,
  input  logic [OUT-1:0]                cand_out,
  output logic [IN-1:0]                 cand_inp,
  output logic                          busy,
  output logic                          done,
  output logic [FIT_W-1:0]              fitness,
  output logic                          perfect
);
  localparam int NV = 1 << IN;
  localparam int PW = $clog2(OUT + 1);
  localparam int CW = $clog2(SETTLE + 1);
  fit_state_t              r_state, w_next;
  logic [OUT-1:0][NV-1:0]  r_tgt;
  logic [IN-1:0]           r_v;
  logic [CW-1:0]           r_cnt;
  logic [FIT_W-1:0]        r_acc, r_fit, w_sum;
  logic                    r_perf;
  logic [OUT-1:0]          w_col;
  logic [PW-1:0]           w_pop;
  logic                    w_settled, w_last;
  assign w_settled = r_cnt == CW'(SETTLE - 1);
  assign w_last    = &r_v;
  assign w_sum     = r_acc + FIT_W'(w_pop);
  // expected output column of the latched truth table for the current vector
  always_comb begin
    w_col = '0;
    for (int o = 0; o < OUT; o++) w_col[o] = r_tgt[o][r_v];
  end
  match_popcount #(.W(OUT), .CW(PW)) u_pop (
    .i_a   (cand_out),
    .i_b   (w_col),
    .o_cnt (w_pop)
  );
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // next state: hold each vector SETTLE cycles, sample once, finish after the last vector
  always_comb
    w_next = r_state == IDLE   ? (start ? APPLY : IDLE) :
             r_state == APPLY  ? (w_settled ? SAMPLE : APPLY) :
             r_state == SAMPLE ? (w_last ? DONE : APPLY) : IDLE;
  // outputs; fitness is loaded on the last sample so it is already valid during DONE
  always_comb begin
    busy     = r_state != IDLE;
    done     = r_state == DONE;
    cand_inp = r_v;
    fitness  = r_fit;
    perfect  = r_perf;
  end
  // datapath: target latch, vector/settle counters and match accumulator
  always_ff @(posedge clk)
    if (rst) begin
      r_v    <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_fit  <= '0;
      r_perf <= 1'b0;
    end else
      case (r_state)
        IDLE:
          if (start) begin
            r_tgt <= target;
            r_acc <= '0;
            r_v   <= '0;
            r_cnt <= '0;
          end
        APPLY: r_cnt <= r_cnt + CW'(1);
        SAMPLE: begin
          r_acc <= w_sum;
          if (w_last) begin
            r_fit  <= w_sum;
            r_perf <= w_sum == FIT_W'(OUT * NV);
          end else begin
            r_v   <= r_v + IN'(1);
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
endmodule

// File: tb/tb_fitness_evaluator.sv
// tb_fitness_evaluator: randomized scoreboard bench with a settling grid model
module tb_fitness_evaluator;
  localparam int IN = 2, OUT = 2, SETTLE = 2, NV = 4, FW = 4;
  localparam int LAT = NV * (SETTLE + 1) + 1;
  typedef logic [OUT-1:0][NV-1:0] tt_t;
  typedef struct {int fit; bit perf; int ks;} exp_t;
  logic clk = 0, rst = 1, start = 0;
  tt_t target = '0;
  logic [OUT-1:0] cand_out;
  logic [IN-1:0] cand_inp;
  logic busy, done, perfect;
  logic [FW-1:0] fitness;
  fitness_evaluator #(.IN(IN), .OUT(OUT), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .cand_out(cand_out),
    .cand_inp(cand_inp), .busy(busy), .done(done), .fitness(fitness), .perfect(perfect)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, cur_ks = 0, n_done = 0;
  int age = 0, busy_len = 0;
  bit sweep_bad = 0, prev_busy = 0;
  logic [IN-1:0] prev_inp = '0;
  logic [OUT-1:0] grid [NV];
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int model(input tt_t tg);
    int c = 0;
    for (int v = 0; v < NV; v++)
      for (int o = 0; o < OUT; o++) c += (grid[v][o] == tg[o][v]) ? 1 : 0;
    return c;
  endfunction
  // grid model (garbage until settled) plus output monitor
  always @(negedge clk) begin
    cyc++;
    if (cand_inp != prev_inp || (busy && !prev_busy)) age = 0; else age++;
    cand_out = (age >= SETTLE) ? grid[cand_inp] : OUT'($urandom);
    if (busy && !prev_busy) sweep_bad = 0;
    busy_len = busy ? busy_len + 1 : 0;
    if (busy && !done && cand_inp != IN'((cyc - cur_ks - 1) / (SETTLE + 1))) sweep_bad = 1;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no pending evaluation", cyc);
      end else begin
        e = sb.pop_front();
        check("fitness", int'(fitness), e.fit);
        check("perfect", int'(perfect), int'(e.perf));
        check("done_cycle", cyc, e.ks + LAT);
        check("busy_len", busy_len, LAT);
        check("sweep_order", int'(sweep_bad), 0);
      end
    end
    prev_inp = cand_inp;
    prev_busy = busy;
  end
  task automatic run(input tt_t tg, input bit disturb);
    int f, d0;
    f = model(tg);
    @(negedge clk); #1;
    target = tg;
    start = 1;
    cur_ks = cyc;
    sb.push_back('{f, f == OUT * NV, cyc});
    d0 = n_done;
    for (int i = 0; i < 3 * LAT && n_done == d0; i++) begin
      @(negedge clk); #1;
      start = disturb && i == 5;
      if (disturb && i == 5) target = ~tg;
    end
    if (n_done == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", 3 * LAT);
    end
    if (disturb) begin
      start = 1;
      @(negedge clk); #1;
      start = 0;
      repeat (20) @(negedge clk);
    end
  endtask
  task automatic abort_run(input tt_t tg);
    @(negedge clk); #1;
    target = tg;
    start = 1;
    cur_ks = cyc;
    @(negedge clk); #1;
    start = 0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_vec_before", int'(cand_inp), 2);
    rst = 1;
    @(negedge clk); #1;
    rst = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_inp", int'(cand_inp), 0);
    check("abort_fitness", int'(fitness), 0);
    check("abort_done", int'(done), 0);
    repeat (20) @(negedge clk);
  endtask
  initial begin
    tt_t tgp, tg1, tr;
    logic [OUT*NV-1:0] rb;
    for (int v = 0; v < NV; v++) grid[v] = {v[0] ^ v[1], v[0] & v[1]};
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fitness", int'(fitness), 0);
    check("rst_perfect", int'(perfect), 0);
    check("rst_inp", int'(cand_inp), 0);
    rst = 0;
    for (int v = 0; v < NV; v++)
      for (int o = 0; o < OUT; o++) tgp[o][v] = grid[v][o];
    run(tgp, 0);
    run(~tgp, 0);
    tg1 = tgp;
    tg1[1][2] = ~tg1[1][2];
    run(tg1, 0);
    run(tgp, 1);
    abort_run(tgp);
    run(tgp, 0);
    repeat (8) begin
      for (int v = 0; v < NV; v++) grid[v] = OUT'($urandom);
      rb = (OUT * NV)'($urandom);
      tr = rb;
      run(tr, 0);
    end
    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
